load_store_unit: RTL and testbench

//  Parametrised successor to the flat data-memory wiring: sits between ALU/register bank/main controller
//  and a synchronous, byte-enabled data memory. Handles RV32/RV64 byte, half, word (and double) loads/stores:

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/load_store_unit_load_extender.sv | 28 ++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} lsu_state_t;

  // Byte-lane mask of an access before it is shifted to its offset.
  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] off);
    case (funct3[1:0])
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~off[0];
      2'b10:   is_aligned = (off[1:0] == 2'b00);
      default: is_aligned = (off == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// Picks the addressed bytes out of a raw memory row and sign/zero-extends them.
module load_extender
  import lsu_pkg::*;
#(
  parameter int data_bits = 32
) (
  input  logic [data_bits-1:0]            row,
  input  logic [$clog2(data_bits/8)-1:0]  off,
  input  logic [2:0]                      funct3,
  output logic [data_bits-1:0]            load_data
);

  logic [data_bits-1:0] shifted;

  always_comb begin
    shifted = row >> {off, 3'b000};
    case (funct3)
      F3_B:    load_data = data_bits'($signed(shifted[7:0]));
      F3_H:    load_data = data_bits'($signed(shifted[15:0]));
      F3_W:    load_data = data_bits'($signed(shifted[31:0]));
      F3_BU:   load_data = data_bits'(shifted[7:0]);
      F3_HU:   load_data = data_bits'(shifted[15:0]);
      F3_WU:   load_data = data_bits'(shifted[31:0]);
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core and a synchronous byte-enabled data memory.
// state  | meaning
// IDLE   | waiting for a request; faults are flagged here combinationally
// ACCESS | single memory strobe cycle with the registered address/lanes
// WAIT   | load only: down-counter covers the remaining read latency
// DONE   | store retires / load data extended and load_valid pulsed
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int data_bits    = 32,
  parameter int addr_bits    = 32,
  parameter int read_latency = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [addr_bits-1:0]                        address,
  input  logic [data_bits-1:0]                        store_data,
  input  logic [2:0]                                  funct3,
  input  logic                                        memory_read,
  input  logic                                        memory_write,
  output logic [addr_bits-$clog2(data_bits/8)-1:0]    mem_address,
  output logic [data_bits-1:0]                        mem_write_data,
  output logic [data_bits/8-1:0]                      mem_byte_enable,
  output logic                                        mem_write_enable,
  output logic                                        mem_read_enable,
  input  logic [data_bits-1:0]                        mem_read_data,
  output logic [data_bits-1:0]                        load_data,
  output logic                                        load_valid,
  output logic                                        stall,
  output logic                                        access_fault
);

  localparam int lanes     = data_bits / 8;
  localparam int off_bits  = $clog2(lanes);
  localparam int cnt_bits  = $clog2(read_latency + 1);
  localparam int wait_load = (read_latency > 1) ? read_latency - 2 : 0;

  lsu_state_t            state;
  logic [cnt_bits-1:0]   wait_cnt;
  logic                  is_load_q;
  logic [off_bits-1:0]   off_q;
  logic [2:0]            funct3_q;
  logic [data_bits-1:0]  held_data;

  logic                  req;
  logic                  f3_illegal;
  logic                  fault;
  logic                  accept;
  logic [off_bits-1:0]   off;
  logic [lanes-1:0]      lane_mask;
  logic [data_bits-1:0]  repl_data;
  logic [data_bits-1:0]  extended;

  always_comb begin
    req        = memory_read | memory_write;
    off        = address[off_bits-1:0];
    f3_illegal = (funct3 == 3'b111) ||
                 ((data_bits == 32) && ((funct3 == F3_D) || (funct3 == F3_WU)));
    fault      = f3_illegal || (memory_read && memory_write) ||
                 !is_aligned(funct3, address[2:0]);
    accept     = (state == IDLE) && req && !fault;
    lane_mask  = lanes'(size_mask(funct3)) << off;
    case (funct3[1:0])
      2'b00:   repl_data = {lanes{store_data[7:0]}};
      2'b01:   repl_data = {(lanes/2){store_data[15:0]}};
      2'b10:   repl_data = {(lanes/4){store_data[31:0]}};
      default: repl_data = store_data;
    endcase
  end

  assign access_fault = (state == IDLE) && req && fault;
  assign stall        = accept || (state == ACCESS) || (state == WAIT);
  // The raw row is only valid during DONE, so the fresh result bypasses the holding register.
  assign load_data    = load_valid ? extended : held_data;

  load_extender #(.data_bits(data_bits)) u_load_extender (
    .row       (mem_read_data),
    .off       (off_q),
    .funct3    (funct3_q),
    .load_data (extended)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      is_load_q        <= 1'b0;
      off_q            <= '0;
      funct3_q         <= '0;
      held_data        <= '0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_byte_enable  <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      load_valid       <= 1'b0;
    end else begin
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_byte_enable  <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      load_valid       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state            <= ACCESS;
            is_load_q        <= memory_read;
            off_q            <= off;
            funct3_q         <= funct3;
            mem_address      <= address[addr_bits-1:off_bits];
            mem_write_enable <= memory_write;
            mem_read_enable  <= memory_read;
            if (memory_write) begin
              mem_byte_enable <= lane_mask;
              mem_write_data  <= repl_data;
            end
          end
        end
        ACCESS: begin
          if (is_load_q && (read_latency > 1)) begin
            state    <= WAIT;
            wait_cnt <= cnt_bits'(wait_load);
          end else begin
            state      <= DONE;
            load_valid <= is_load_q;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state      <= DONE;
            load_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - cnt_bits'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          if (is_load_q) held_data <= extended;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-addressed reference memory plus a latency-pipelined row memory model.
module tb_load_store_unit;
  localparam int DB = 32;
  localparam int AB = 32;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] store_data = '0;
  logic [2:0]  funct3 = '0;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic [29:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_read_data;
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall;
  logic        access_fault;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ref_mem [512];
  logic [31:0] row_mem [128];
  logic [31:0] rd_pipe [RL];
  logic        mem_init = 1'b1;

  always #5 clk = ~clk;

  load_store_unit #(.data_bits(DB), .addr_bits(AB), .read_latency(RL)) dut (
    .clk(clk), .rst(rst), .address(address), .store_data(store_data), .funct3(funct3),
    .memory_read(memory_read), .memory_write(memory_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data), .load_data(load_data), .load_valid(load_valid),
    .stall(stall), .access_fault(access_fault)
  );

  // Row memory driven only by the DUT's strobes; read data appears RL cycles after the strobe.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int r = 0; r < 128; r++)
        row_mem[r] <= {ref_mem[4*r+3], ref_mem[4*r+2], ref_mem[4*r+1], ref_mem[4*r]};
    end else if (mem_write_enable) begin
      for (int i = 0; i < 4; i++)
        if (mem_byte_enable[i]) row_mem[mem_address[6:0]][8*i +: 8] <= mem_write_data[8*i +: 8];
    end
    for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= mem_read_enable ? row_mem[mem_address[6:0]] : $urandom;
  end
  assign mem_read_data = rd_pipe[RL-1];

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int nb;
    logic [31:0] v;
    nb = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[(int'(addr[8:0]) + i) % 512];
    if (!f3[2] && nb < 4 && v[8*nb-1])
      for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Advance one cycle; while busy the core inputs are scrambled to prove the DUT ignores them.
  task automatic next_cycle(input bit busy);
    @(posedge clk); #1;
    address      = $urandom;
    store_data   = $urandom;
    funct3       = 3'($urandom);
    memory_read  = busy ? 1'($urandom) : 1'b0;
    memory_write = busy ? 1'($urandom) : 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input string tag, input bit wr, input bit rd, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data);
    int nb;
    bit ok;
    logic [31:0] exp_ld;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    nb = 1 << f3[1:0];
    ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111) && !(wr && rd) && ((addr % nb) == 0);
    exp_be = 4'(((1 << nb) - 1) << (addr % 4));
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = data[8*(i % nb) +: 8];
    exp_ld = (rd && ok) ? ref_load(f3, addr) : '0;

    @(posedge clk); #1;
    memory_write = wr; memory_read = rd; funct3 = f3; address = addr; store_data = data;
    @(negedge clk);
    checks++;
    if (access_fault !== !ok) begin failures++; $display("FAIL %s fault: got %b want %b", tag, access_fault, !ok); end
    checks++;
    if (stall !== ok) begin failures++; $display("FAIL %s req stall: got %b want %b", tag, stall, ok); end
    checks++;
    if ({mem_write_enable, mem_read_enable, load_valid} !== 3'b000) begin
      failures++; $display("FAIL %s req strobes: got %b want 000", tag, {mem_write_enable, mem_read_enable, load_valid});
    end

    if (!ok) begin
      next_cycle(1'b0);
      checks++;
      if ({mem_write_enable, mem_read_enable, mem_byte_enable, stall, access_fault} !== 8'h00) begin
        failures++; $display("FAIL %s post-fault outputs: got %b want 0", tag,
                             {mem_write_enable, mem_read_enable, mem_byte_enable, stall, access_fault});
      end
      return;
    end

    next_cycle(1'b1);
    checks++;
    if ({mem_write_enable, mem_read_enable} !== {wr, rd}) begin
      failures++; $display("FAIL %s access strobes: got %b want %b", tag, {mem_write_enable, mem_read_enable}, {wr, rd});
    end
    checks++;
    if (mem_address !== addr[31:2]) begin failures++; $display("FAIL %s mem_address: got %h want %h", tag, mem_address, addr[31:2]); end
    checks++;
    if (mem_byte_enable !== (wr ? exp_be : 4'h0)) begin
      failures++; $display("FAIL %s byte_enable: got %b want %b", tag, mem_byte_enable, wr ? exp_be : 4'h0);
    end
    if (wr) begin
      checks++;
      if (mem_write_data !== exp_wd) begin failures++; $display("FAIL %s write_data: got %h want %h", tag, mem_write_data, exp_wd); end
      for (int i = 0; i < nb; i++) ref_mem[(int'(addr[8:0]) + i) % 512] = data[8*i +: 8];
    end
    checks++;
    if ({stall, access_fault} !== 2'b10) begin failures++; $display("FAIL %s access stall/fault: got %b want 10", tag, {stall, access_fault}); end

    for (int w = 0; w < (rd ? RL - 1 : 0); w++) begin
      next_cycle(1'b1);
      checks++;
      if ({stall, access_fault, load_valid, mem_write_enable, mem_read_enable, mem_byte_enable} !== 9'b1_0000_0000) begin
        failures++; $display("FAIL %s wait %0d outputs: got %b want 100000000", tag, w,
                             {stall, access_fault, load_valid, mem_write_enable, mem_read_enable, mem_byte_enable});
      end
    end

    next_cycle(1'b0);
    checks++;
    if ({stall, load_valid} !== {1'b0, rd}) begin
      failures++; $display("FAIL %s done stall/valid: got %b want %b", tag, {stall, load_valid}, {1'b0, rd});
    end
    checks++;
    if ({mem_write_enable, mem_read_enable, mem_byte_enable} !== 6'b0) begin
      failures++; $display("FAIL %s done strobes: got %b want 0", tag, {mem_write_enable, mem_read_enable, mem_byte_enable});
    end
    if (rd) begin
      checks++;
      if (load_data !== exp_ld) begin failures++; $display("FAIL %s load_data: got %h want %h", tag, load_data, exp_ld); end
    end

    next_cycle(1'b0);
    checks++;
    if (load_valid !== 1'b0) begin failures++; $display("FAIL %s valid after done: got %b want 0", tag, load_valid); end
    if (rd) begin
      checks++;
      if (load_data !== exp_ld) begin failures++; $display("FAIL %s load_data hold: got %h want %h", tag, load_data, exp_ld); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_write_enable, mem_read_enable, mem_byte_enable} !== 6'b0) begin
      failures++; $display("FAIL reset strobes: got %b want 0", {mem_write_enable, mem_read_enable, mem_byte_enable});
    end
    checks++;
    if ({mem_address, mem_write_data} !== 62'b0) begin
      failures++; $display("FAIL reset mem bus: got %h %h want 0 0", mem_address, mem_write_data);
    end
    checks++;
    if ({load_data, load_valid, stall, access_fault} !== 35'b0) begin
      failures++; $display("FAIL reset core outputs: got %h %b%b%b want 0", load_data, load_valid, stall, access_fault);
    end
  endtask

  task automatic test_stores();
    run_op("sw_104", 1'b1, 1'b0, lsu_pkg::F3_W, 32'h104, 32'hDEADBEEF);
    run_op("sb_103", 1'b1, 1'b0, lsu_pkg::F3_B, 32'h103, 32'h123456A5);
    run_op("sh_102", 1'b1, 1'b0, lsu_pkg::F3_H, 32'h102, 32'h0000BEEF);
    run_op("sb_1f0", 1'b1, 1'b0, lsu_pkg::F3_B, 32'h1F0, 32'h0000007E);
  endtask

  task automatic test_loads();
    run_op("sw_100", 1'b1, 1'b0, lsu_pkg::F3_W,  32'h100, 32'h00008000);
    run_op("lb_101", 1'b0, 1'b1, lsu_pkg::F3_B,  32'h101, 32'h0);
    run_op("lbu_101", 1'b0, 1'b1, lsu_pkg::F3_BU, 32'h101, 32'h0);
    run_op("sw_000", 1'b1, 1'b0, lsu_pkg::F3_W,  32'h000, 32'hF00D0000);
    run_op("lhu_002", 1'b0, 1'b1, lsu_pkg::F3_HU, 32'h002, 32'h0);
    run_op("lh_002", 1'b0, 1'b1, lsu_pkg::F3_H,  32'h002, 32'h0);
    run_op("lw_104", 1'b0, 1'b1, lsu_pkg::F3_W,  32'h104, 32'h0);
  endtask

  task automatic test_latency();
    int valid_at;
    int stall_cycles;
    logic [31:0] exp_ld;
    valid_at = -1;
    stall_cycles = 0;
    exp_ld = ref_load(lsu_pkg::F3_W, 32'h104);
    @(posedge clk); #1;
    memory_read = 1'b1; funct3 = lsu_pkg::F3_W; address = 32'h104;
    @(negedge clk);
    for (int c = 1; c <= 10 && valid_at < 0; c++) begin
      if (stall) stall_cycles++;
      if (load_valid) valid_at = c;
      else next_cycle(1'b0);
    end
    checks++;
    if (valid_at != 5) begin failures++; $display("FAIL latency load_valid cycle: got %0d want 5", valid_at); end
    checks++;
    if (stall_cycles != 4) begin failures++; $display("FAIL latency stall cycles: got %0d want 4", stall_cycles); end
    checks++;
    if (load_data !== exp_ld) begin failures++; $display("FAIL latency load_data: got %h want %h", load_data, exp_ld); end
    next_cycle(1'b0);
  endtask

  task automatic test_faults();
    run_op("lh_mis",  1'b0, 1'b1, lsu_pkg::F3_H,  32'h003, 32'h0);
    run_op("lw_mis",  1'b0, 1'b1, lsu_pkg::F3_W,  32'h002, 32'h0);
    run_op("ld_rv32", 1'b0, 1'b1, lsu_pkg::F3_D,  32'h000, 32'h0);
    run_op("lwu_rv32", 1'b0, 1'b1, lsu_pkg::F3_WU, 32'h000, 32'h0);
    run_op("rw_both", 1'b1, 1'b1, lsu_pkg::F3_W,  32'h000, 32'h11111111);
    run_op("f3_111",  1'b1, 1'b0, 3'b111,         32'h000, 32'h22222222);
    run_op("sw_mis",  1'b1, 1'b0, lsu_pkg::F3_W,  32'h001, 32'h33333333);
    run_op("lw_after_faults", 1'b0, 1'b1, lsu_pkg::F3_W, 32'h000, 32'h0);
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    memory_read = 1'b1; funct3 = lsu_pkg::F3_W; address = 32'h104;
    next_cycle(1'b0);
    next_cycle(1'b0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL rst_wait pre stall: got %b want 1", stall); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_data, load_valid, stall, access_fault, mem_write_enable, mem_read_enable, mem_byte_enable} !== 41'b0) begin
      failures++; $display("FAIL rst_wait outputs: got %h %b want 0", load_data,
                           {load_valid, stall, access_fault, mem_write_enable, mem_read_enable, mem_byte_enable});
    end
    for (int c = 0; c < 3; c++) begin
      next_cycle(1'b0);
      checks++;
      if ({load_valid, stall} !== 2'b00) begin
        failures++; $display("FAIL rst_wait stale cycle %0d: got %b want 00", c, {load_valid, stall});
      end
    end
    run_op("lw_after_rst", 1'b0, 1'b1, lsu_pkg::F3_W, 32'h104, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      bit wr;
      bit rd;
      logic [2:0] f3;
      logic [31:0] a;
      int k;
      wr = 1'($urandom_range(0, 1));
      rd = !wr;
      if ($urandom_range(0, 19) == 0) begin wr = 1'b1; rd = 1'b1; end
      k = $urandom_range(0, 4);
      f3 = wr ? 3'($urandom_range(0, 2)) : ((k < 3) ? 3'(k) : 3'(k + 1));
      if ($urandom_range(0, 19) == 0) f3 = 3'($urandom);
      a = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 9) != 0) a = a & ~32'((1 << f3[1:0]) - 1);
      run_op($sformatf("rnd%0d", n), wr, rd, f3, a, $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
    test_reset();
    test_stores();
    test_loads();
    test_latency();
    test_faults();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
